// File: rtl/layer0_writer_pkg.sv
// layer0_writer_pkg
//   Shared constants for the layer-0 result writer and its tests:
//   image geometry (IMG_LOG2, NPIX), data widths (IN_W, OUT_W), the
//   IDLE/RUN/DONE state encoding, and the ReLU transfer function.
package layer0_writer_pkg;

  localparam int IMG_LOG2 = 6;
  localparam int NPIX     = 1 << (2 * IMG_LOG2);
  localparam int IN_W     = 19;
  localparam int OUT_W    = 20;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Negative results clamp to 0; non-negative ones zero-extend.
  function automatic logic [OUT_W-1:0] relu(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] y;
    y = '0;
    if (!x[IN_W-1]) y[IN_W-1:0] = x;
    return y;
  endfunction

endpackage

// File: rtl/layer0_writer_maxpool_line.sv
// layer0_writer_maxpool_line
//   On-the-fly 2x2 / stride-2 max-pool over a raster pixel stream.
//   A line buffer keeps one partial maximum per column pair from the even
//   row; the odd row folds it in and emits one pooled word per window.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   i_stb            : pixel accepted this cycle
//   i_v              : ReLU'd pixel value
//   i_row_odd        : r[0] of the pixel
//   i_col            : full column index c
//   i_row_pair       : r[IMG_LOG2-1:1], upper part of the pooled address
//   o_wr/o_addr/o_data : registered layer-1 write
module maxpool_line #(
  parameter int COL_LOG2 = 6,
  parameter int W        = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_stb,
  input  logic [W-1:0]          i_v,
  input  logic                  i_row_odd,
  input  logic [COL_LOG2-1:0]   i_col,
  input  logic [COL_LOG2-2:0]   i_row_pair,
  output logic                  o_wr,
  output logic [2*COL_LOG2-3:0] o_addr,
  output logic [W-1:0]          o_data
);

  localparam int CP_W = COL_LOG2 - 1;
  localparam int LB_N = 1 << CP_W;

  logic [W-1:0]          lb_q [LB_N];
  logic [W-1:0]          hold_q, hold_d;
  logic                  wr_q, wr_d;
  logic [2*COL_LOG2-3:0] addr_q, addr_d;
  logic [W-1:0]          data_q, data_d;
  logic                  lb_we;
  logic [W-1:0]          lb_wdata;
  logic [CP_W-1:0]       cp;
  logic [W-1:0]          lb_rd;

  function automatic logic [W-1:0] vmax(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign cp    = i_col[COL_LOG2-1:1];
  assign lb_rd = lb_q[cp];

  always_comb begin
    hold_d   = hold_q;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    lb_we    = 1'b0;
    lb_wdata = vmax(hold_q, i_v);
    if (i_stb) begin
      unique case ({i_row_odd, i_col[0]})
        2'b00: hold_d = i_v;
        2'b01: lb_we  = 1'b1;                 // even-row pair max parked per column pair
        2'b10: hold_d = vmax(lb_rd, i_v);     // fold upper pair into the lower-left pixel
        2'b11: begin
          wr_d   = 1'b1;
          addr_d = {i_row_pair, cp};
          data_d = vmax(hold_q, i_v);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      hold_q <= hold_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Row 0 of every frame writes every entry before row 1 reads it, so the
  // buffer carries no reset.
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[cp] <= lb_wdata;
  end

  assign o_wr   = wr_q;
  assign o_addr = addr_q;
  assign o_data = data_q;

endmodule

// File: rtl/layer0_writer.sv
// layer0_writer
//   Consumes the convolution engine's pixel stream, applies ReLU and writes
//   each result in raster order to the layer-0 result memory. With
//   L1_POOL_EN defined, a 2x2/stride-2 max-pooled map is also written to the
//   layer-1 memory; otherwise the layer-1 port is tied to 0.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   i_start               : frame start pulse (IDLE only)
//   i_valid, i_data       : pixel stream, no backpressure
//   o_busy                : state is not IDLE
//   o_done                : one-cycle pulse with the last frame writes
//   o_l0_wr/addr/data     : layer-0 memory write port
//   o_l1_wr/addr/data     : layer-1 memory write port (pooled)
// All outputs are registered.
module layer0_writer #(
  parameter int IMG_LOG2 = layer0_writer_pkg::IMG_LOG2,
  parameter int IN_W     = layer0_writer_pkg::IN_W,
  parameter int OUT_W    = layer0_writer_pkg::OUT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [IN_W-1:0]       i_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_l0_wr,
  output logic [2*IMG_LOG2-1:0] o_l0_addr,
  output logic [OUT_W-1:0]      o_l0_data,
  output logic                  o_l1_wr,
  output logic [2*IMG_LOG2-3:0] o_l1_addr,
  output logic [OUT_W-1:0]      o_l1_data
);

  import layer0_writer_pkg::*;

  localparam int               PIX_W    = 2 * IMG_LOG2;
  localparam logic [PIX_W-1:0] LAST_PIX = '1;

  state_e           state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             l0_wr_q, l0_wr_d;
  logic [PIX_W-1:0] l0_addr_q, l0_addr_d;
  logic [OUT_W-1:0] l0_data_q, l0_data_d;
  logic [OUT_W-1:0] relu_v;

  // Generic-width ReLU; identical to the package relu() at default widths.
  always_comb begin
    relu_v = '0;
    relu_v[IN_W-1:0] = i_data;
    if (i_data[IN_W-1]) relu_v = '0;
  end

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    done_d    = 1'b0;
    l0_wr_d   = 1'b0;
    l0_addr_d = l0_addr_q;
    l0_data_d = l0_data_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          pix_d   = '0;
        end
      end
      RUN: begin
        if (i_valid) begin
          l0_wr_d   = 1'b1;
          l0_addr_d = pix_q;
          l0_data_d = relu_v;
          pix_d     = pix_q + 1'b1;
          if (pix_q == LAST_PIX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered from the next state so o_busy tracks the state exactly.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      l0_wr_q   <= 1'b0;
      l0_addr_q <= '0;
      l0_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      l0_wr_q   <= l0_wr_d;
      l0_addr_q <= l0_addr_d;
      l0_data_q <= l0_data_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_l0_wr   = l0_wr_q;
  assign o_l0_addr = l0_addr_q;
  assign o_l0_data = l0_data_q;

`ifdef L1_POOL_EN
  logic accept;
  assign accept = (state_q == RUN) && i_valid;

  maxpool_line #(
    .COL_LOG2 (IMG_LOG2),
    .W        (OUT_W)
  ) u_pool (
    .clk        (clk),
    .reset      (reset),
    .i_stb      (accept),
    .i_v        (relu_v),
    .i_row_odd  (pix_q[IMG_LOG2]),
    .i_col      (pix_q[IMG_LOG2-1:0]),
    .i_row_pair (pix_q[PIX_W-1:IMG_LOG2+1]),
    .o_wr       (o_l1_wr),
    .o_addr     (o_l1_addr),
    .o_data     (o_l1_data)
  );
`else
  assign o_l1_wr   = 1'b0;
  assign o_l1_addr = '0;
  assign o_l1_data = '0;
`endif

endmodule

// File: tb/tb_layer0_writer.sv
// Randomized scoreboard bench for layer0_writer. Stimulus pushes expected
// writes (with their expected cycle) into queues; a negedge monitor pops and
// compares whenever a write appears.
module tb_layer0_writer;

  localparam int NP = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic [18:0] i_data = '0;
  logic        o_busy, o_done, o_l0_wr, o_l1_wr;
  logic [11:0] o_l0_addr;
  logic [9:0]  o_l1_addr;
  logic [19:0] o_l0_data, o_l1_data;

  layer0_writer dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_l0_wr   (o_l0_wr),
    .o_l0_addr (o_l0_addr),
    .o_l0_data (o_l0_data),
    .o_l1_wr   (o_l1_wr),
    .o_l1_addr (o_l1_addr),
    .o_l1_data (o_l1_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
    int data;
    bit done;
  } exp_t;

  exp_t l0_q[$];
  exp_t l1_q[$];
  exp_t e0, e1;
  int   relu_m[NP];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ReLU on a 19-bit two's complement value held as a non-negative int.
  function automatic int mrelu(input int x);
    return (x >= (1 << 18)) ? 0 : x;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // mode 0: data = pix; mode 1: random with ReLU edge values first;
  // modes 2..5: window-0 maximum (100) at position mode-2, 1 elsewhere;
  // mode 6: window 0 all tied at 7.
  function automatic int gen(input int mode, input int p);
    int edges[4];
    int win_pos;
    edges = '{'h7FFFF, 'h40000, 'h3FFFF, 0};
    win_pos = (p == 0) ? 0 : (p == 1) ? 1 : (p == 64) ? 2 : (p == 65) ? 3 : -1;
    if (mode == 0) return p;
    if (mode == 1 && p < 4) return edges[p];
    if (mode >= 2 && mode <= 5 && win_pos >= 0) return (win_pos == mode - 2) ? 100 : 1;
    if (mode == 6 && win_pos >= 0) return 7;
    return int'($urandom & 32'h7FFFF);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (o_l0_wr) begin
        if (l0_q.size() == 0) chk("l0_unexpected_write", 1, 0);
        else begin
          e0 = l0_q.pop_front();
          chk("l0_cycle", cyc, e0.cyc);
          chk("l0_addr", o_l0_addr, e0.addr);
          chk("l0_data", o_l0_data, e0.data);
          chk("done_with_l0", o_done, e0.done);
`ifndef L1_POOL_EN
          chk("l1_tied_off", longint'(o_l1_wr) | longint'(o_l1_addr) | longint'(o_l1_data), 0);
`endif
        end
      end else if (o_done) chk("done_without_write", 1, 0);
`ifdef L1_POOL_EN
      if (o_l1_wr) begin
        if (l1_q.size() == 0) chk("l1_unexpected_write", 1, 0);
        else begin
          e1 = l1_q.pop_front();
          chk("l1_cycle", cyc, e1.cyc);
          chk("l1_addr", o_l1_addr, e1.addr);
          chk("l1_data", o_l1_data, e1.data);
        end
      end
`endif
    end
  end

  task automatic chk_quiet(input string nm);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_strobes"}, longint'(o_l0_wr) | longint'(o_l1_wr) | longint'(o_done), 0);
    chk({nm, "_addr"}, longint'(o_l0_addr) | longint'(o_l1_addr), 0);
    chk({nm, "_data"}, longint'(o_l0_data) | longint'(o_l1_data), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && (l0_q.size() != 0 || l1_q.size() != 0); i++) @(negedge clk);
    if (l0_q.size() != 0 || l1_q.size() != 0)
      chk("drain_timeout", l0_q.size() + l1_q.size(), 0);
    l0_q.delete();
    l1_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_valid = 1'b1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("in_reset");
    reset = 1'b0;
  endtask

  task automatic frame(input int mode, input int npx, input int bub_pct);
    int p, v, r, c;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_valid = 1'($urandom_range(0, 1));  // must be ignored in IDLE
    i_data  = 19'($urandom);
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    p = 0;
    while (p < npx) begin
      if (int'($urandom_range(0, 99)) < bub_pct) begin
        i_valid = 1'b0;
        i_data  = 19'($urandom);
        i_start = 1'($urandom_range(0, 1));  // ignored outside IDLE
      end else begin
        i_start = 1'b0;
        v = gen(mode, p);
        i_valid = 1'b1;
        i_data  = 19'(v);
        relu_m[p] = mrelu(v);
        l0_q.push_back('{cyc + 1, p, relu_m[p], p == NP - 1});
        r = p / 64;
        c = p % 64;
`ifdef L1_POOL_EN
        if ((r % 2 == 1) && (c % 2 == 1))
          l1_q.push_back('{cyc + 1, (r / 2) * 32 + c / 2,
                           max4(relu_m[p - 65], relu_m[p - 64], relu_m[p - 1], relu_m[p]), 0});
`endif
        p++;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    if (npx == NP) begin
      chk("busy_in_done", o_busy, 1);
      @(posedge clk); #1;
      chk("busy_after_done", o_busy, 0);
      chk("done_one_cycle", o_done, 0);
    end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two cycles, then sit with valid high and no start.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    reset   = 1'b0;
    i_valid = 1'b1;
    i_data  = 19'h12345;
    repeat (4) begin
      @(posedge clk); #1;
      chk_quiet("idle_no_start");
    end
    i_valid = 1'b0;

    frame(0, NP, 0);      // raster frame, data = pix
    frame(1, NP, 0);      // ReLU edges then random data
    frame(0, NP, 50);     // gapped stream

    for (int m = 2; m <= 6; m++) begin
      frame(m, 66, 0);    // window 0 complete at pixel 65
      do_reset();
    end

    frame(1, 1000, 20);   // abandoned mid-frame
    do_reset();
    chk("busy_after_midreset", o_busy, 0);
    frame(1, NP, 10);     // new frame restarts from address 0

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/layer0_writer.md
# layer0_writer

Consumer end of the layer-0 convolution result stream. Accepts the `valid`/`data` pixel stream produced by the convolution engine and applies ReLU. Writes each result in raster order to the layer-0 result memory. Optionally performs 2x2/stride-2 max-pooling on the fly and writes the pooled map to the layer-1 result memory. It sits between the convolution engine output and the result RAMs, and signals frame completion to the top-level controller.

## Interface
Parameters:
- `IMG_LOG2`, default 6: log2 of the image side, so the image is 64x64 and a frame is 4096 pixels.
- `IN_W`, default 19: input result width, signed two's complement.
- `OUT_W`, default 20: memory word width.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high. This is the already-decided clocking: one clock, reset synchronous and active-high.
- `i_start`, in, 1: single-cycle frame start pulse. Honoured only in IDLE.
- `i_valid`, in, 1: input pixel strobe. There is no backpressure; every valid in RUN is consumed.
- `i_data`, in, `IN_W`: convolution result.
- `o_busy`, out, 1: high whenever the state is not IDLE.
- `o_done`, out, 1: single-cycle frame-complete pulse.
- `o_l0_wr`, out, 1: layer-0 memory write enable.
- `o_l0_addr`, out, 2*`IMG_LOG2`: layer-0 write address.
- `o_l0_data`, out, `OUT_W`: layer-0 write data.
- `o_l1_wr`, out, 1: layer-1 memory write enable.
- `o_l1_addr`, out, 2*`IMG_LOG2`-2: layer-1 write address.
- `o_l1_data`, out, `OUT_W`: layer-1 write data.

## Operation
State machine:
- States are IDLE, RUN and DONE.
- IDLE goes to RUN on `i_start`. The pixel counter `pix` (12 bits) is cleared at that point.
- In IDLE, `i_valid` is ignored, including when it arrives in the same cycle as `i_start`.
- `i_start` while in RUN or DONE is ignored.
- RUN goes to DONE on the clock edge that accepts pixel 4095.
- DONE goes to IDLE after one cycle.

Pixel handling:
- Each accepted pixel has position `r = pix[11:6]`, `c = pix[5:0]`. `pix` increments once per accepted pixel.
- ReLU: if `i_data[IN_W-1]` is set, the output is 0. Otherwise the output is `{1'b0, i_data}` zero-extended to `OUT_W`.
- Layer-0 write: address is `pix`, data is the ReLU value.

Pooling (when enabled), with `cp = c[5:1]`, a 32-entry line buffer `lb`, and a `hold` register:
- Even row, even column: `hold = v`.
- Even row, odd column: `lb[cp] = max(hold, v)`.
- Odd row, even column: `hold = max(lb[cp], v)`.
- Odd row, odd column: layer-1 write with address `{r[5:1], cp}` and data `max(hold, v)`.
- Comparisons are unsigned on the ReLU'd values. On a tie, either operand may be taken since the values are equal.
- Row 0 fully writes `lb` before any read, so `lb` needs no clearing.

Reset:
- Takes effect at any time, including mid-frame. All outputs are driven to 0 on the next edge and the state returns to IDLE.
- The frame is abandoned. A subsequent `i_start` restarts at address 0.

## Timing
- Reset values: `o_busy`, `o_done`, `o_l0_wr`, `o_l1_wr`, every address and every data output are all 0.
- All outputs are registered.
- Layer-0 write appears exactly 1 cycle after the accepting `i_valid` edge. `o_l0_wr` is high for that one cycle only.
- Layer-1 write appears in the same cycle as the layer-0 write of the odd/odd pixel that completes the window.
- Bubbles (`i_valid` low) produce no writes and do not advance any state. Back-to-back valids produce back-to-back writes.
- `o_done` is asserted in the same cycle as the final writes (layer-0 address 4095, layer-1 address 1023). `o_busy` falls the following cycle.
- Throughput is 1 pixel/cycle. Nothing else constrains the gap between `i_start` and the first `i_valid`.

## Configuration
- `L1_POOL_EN` defined: the pooling path, line buffer and layer-1 write port are active as specified above.
- `L1_POOL_EN` undefined:
  - `lb`, `hold` and all comparators are compiled out.
  - `o_l1_wr`, `o_l1_addr` and `o_l1_data` are held at 0 permanently.
  - Layer-0 behaviour and `o_done` timing are unchanged.

## Structure
- Shared package holds:
  - `IMG_LOG2`, `NPIX = 4096` and the widths `IN_W`/`OUT_W`.
  - The state encoding (IDLE/RUN/DONE as 2-bit localparams).
  - A `relu` function, so the convolution engine's tests can reuse it.
- One sub-module is natural: `maxpool_line`. It owns `lb`, `hold` and the comparators, takes `(v, r[0], c)` plus a strobe, and returns the layer-1 write. It is instantiated only under `L1_POOL_EN`.

## Test plan
- Reset behaviour: assert `reset` for 2 cycles, then release with `i_valid=1` and no start. All outputs stay 0 and `o_busy` stays 0.
- Full raster frame: `i_start`, then 4096 back-to-back valids with `data = pix`.
  - Each layer-0 write shows address n, data n, one cycle after input n.
  - Layer-1 address k carries `(2R+1)*64 + 2C + 1`, where R and C are the row and column of window k.
  - `o_done` coincides with layer-0 address 4095 and layer-1 address 1023.
- ReLU edges: `19'h7FFFF` gives 0; `19'h40000` gives 0; `19'h3FFFF` gives `20'h3FFFF`; 0 gives 0.
- Pool maximum placement: window 0 with the maximum in each of its four positions in turn, e.g. 100 at (0,0) and 1 elsewhere. Layer-1 address 0 gets 100 in every case, and ties yield the tied value.
- Gapped stream: random bubbles (about 50%) over a full frame. Writes are identical to the full-frame case and no writes occur on bubble cycles.
- Mid-frame reset: reset after 1000 pixels, then start a new frame. Outputs are 0 after reset, and the new frame writes from address 0 with correct pooled values in row pair 0.
